prim_arb_resp_router: RTL and testbench
=======================================

PRIM_ARB_RESP_ROUTER -- requirements
Module: prim_arb_resp_router

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning the number of response ports; legal range N >= 2.
REQ-002 The block SHALL have parameter DW, default 32, meaning the response data width.
REQ-003 The block SHALL have parameter Depth, default 4, meaning the maximum number of outstanding transactions; legal range Depth >= 1.
REQ-004 The block SHALL have derived localparam IdxW = $clog2(N) and CntW = $clog2(Depth+1).
REQ-005 The block SHALL have one clock and a synchronous, active-high reset, named as follows.
REQ-006 clk_i  input  1  clock; all state updates on the rising edge.
REQ-007 rst_i  input  1  synchronous active-high reset.
REQ-008 push_i  input  1  request accepted upstream (arbiter valid and ready) this cycle.
REQ-009 push_idx_i  input  IdxW  index of the granted requester.
REQ-010 push_ready_o  output  1  tracking slot free; upstream SHALL gate the arbiter ready with it.
REQ-011 rsp_valid_i  input  1  response beat valid from the shared sink.
REQ-012 rsp_last_i  input  1  final beat of the current response.
REQ-013 rsp_data_i  input  DW  response beat data.
REQ-014 rsp_ready_o  output  1  response beat accepted.
REQ-015 rsp_valid_o  output  N  per-port response valid, at most one bit set.
REQ-016 rsp_last_o  output  1  broadcast copy of rsp_last_i.
REQ-017 rsp_data_o  output  DW  broadcast copy of rsp_data_i.
REQ-018 rsp_ready_i  input  N  per-port response ready.
REQ-019 cnt_o  output  CntW  number of outstanding transactions.
REQ-020 overflow_o  output  1  sticky error: push_i asserted while full.

Function
REQ-021 The block SHALL store push_idx_i in an in-order index FIFO of Depth entries when push_i && push_ready_o.
REQ-022 push_ready_o SHALL equal (cnt_o != Depth), a registered decision with no same-cycle pop bypass.
REQ-023 push_i while full SHALL leave the FIFO, pointers and cnt_o unchanged and set overflow_o from the next cycle until reset.
REQ-024 Read and write pointers SHALL wrap from Depth-1 to 0, and this SHALL also hold for non-power-of-two Depth.
REQ-025 When cnt_o == 0, rsp_valid_o SHALL be all-zero and rsp_ready_o SHALL be 0, which stalls the response without dropping it and without an error.
REQ-026 When cnt_o > 0, with head index h: rsp_valid_o[h] = rsp_valid_i, all other bits 0, and rsp_ready_o = rsp_ready_i[h].
REQ-027 rsp_data_o and rsp_last_o SHALL be combinational copies of the inputs; responses SHALL have zero added latency.
REQ-028 A beat SHALL transfer when rsp_valid_i && rsp_ready_o; the head entry SHALL be popped only on a transferred beat with rsp_last_i = 1.
REQ-029 Non-last beats SHALL keep the head, so all beats of one response route to the same port.
REQ-030 A push never SHALL route a response in the same cycle: an entry becomes the head at the earliest one cycle after the push.
REQ-031 Simultaneous push and pop SHALL leave cnt_o unchanged and advance both pointers.
REQ-032 cnt_o SHALL change by +1 on push-only, -1 on pop-only, and never exceed Depth or go below 0.
REQ-033 rsp_ready_i bits of non-head ports SHALL have no effect.

Reset
REQ-034 While rst_i is sampled high, pointers, cnt_o and overflow_o SHALL clear to 0 at the clock edge; push_ready_o SHALL then be 1, and rsp_valid_o and rsp_ready_o SHALL be 0.
REQ-035 Reset mid-transaction SHALL discard all outstanding entries, including a partially delivered multi-beat response.
REQ-036 Reset SHALL take priority over a simultaneous push or pop.

Verification
REQ-037 N=4, Depth=4: push idx 2,0,3; three single-beat responses with rsp_ready_i=4'b1111 -> rsp_valid_o 4'b0100, 4'b0001, 4'b1000 in order; cnt_o goes 3,2,1,0.
REQ-038 Push idx 1, then a 3-beat response with rsp_ready_i[1] toggling 1,0,1,1 -> all beats on port 1; pop only on the last beat; cnt_o 1 until the last-beat edge, then 0.
REQ-039 Depth=4: 4 pushes -> push_ready_o=0, cnt_o=4; a fifth push_i -> cnt_o stays 4, overflow_o=1 the next cycle and stays 1.
REQ-040 FIFO full, with push and last-beat pop in the same cycle -> push ignored (push_ready_o=0) and cnt_o=3 afterwards; next-cycle push accepted -> cnt_o=4.
REQ-041 Empty, with rsp_valid_i=1 -> rsp_ready_o=0 and rsp_valid_o=0; push idx 3 -> next cycle rsp_valid_o[3]=1 and the beat is accepted.
REQ-042 Depth=3: 7 push/pop pairs with indices 0..6 mod N -> routing order matches push order across pointer wrap; assert rsp_valid_o is onehot0 every cycle.

Source files
------------

// File: rtl/prim_arb_resp_router.sv
// Response router for a shared sink behind an arbiter. Remembers the grant
// index of every accepted request in order and steers each response (all of
// its beats) back to the port that issued it.
module prim_arb_resp_router #(
    parameter  int N     = 8,
    parameter  int DW    = 32,
    parameter  int Depth = 4,
    localparam int IdxW  = $clog2(N),
    localparam int CntW  = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  logic [IdxW-1:0] push_idx_i,
    output logic            push_ready_o,
    input  logic            rsp_valid_i,
    input  logic            rsp_last_i,
    input  logic [DW-1:0]   rsp_data_i,
    output logic            rsp_ready_o,
    output logic [N-1:0]    rsp_valid_o,
    output logic            rsp_last_o,
    output logic [DW-1:0]   rsp_data_o,
    input  logic [N-1:0]    rsp_ready_i,
    output logic [CntW-1:0] cnt_o,
    output logic            overflow_o
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [IdxW-1:0] mem_q [Depth];
    logic [PtrW-1:0] wptr_q, rptr_q;
    logic [CntW-1:0] cnt_q;
    logic            ovf_q;
    logic [IdxW-1:0] head;
    logic            not_empty, do_push, do_pop;

    assign not_empty    = (cnt_q != '0);
    assign push_ready_o = (cnt_q != CntW'(Depth));
    assign do_push      = push_i && push_ready_o;
    assign head         = mem_q[rptr_q];
    assign rsp_ready_o  = not_empty && rsp_ready_i[head];
    assign do_pop       = rsp_valid_i && rsp_ready_o && rsp_last_i;
    assign rsp_last_o   = rsp_last_i;
    assign rsp_data_o   = rsp_data_i;
    assign cnt_o        = cnt_q;
    assign overflow_o   = ovf_q;

    // Steer the valid to the head port only; nothing routes while empty.
    always_comb begin
        rsp_valid_o = '0;
        if (not_empty) rsp_valid_o[head] = rsp_valid_i;
    end

    // Index storage; no reset needed, contents are qualified by cnt_q.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= push_idx_i;
    end

    // Pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            // Explicit wrap so non-power-of-two depths stay in range.
            if (do_push) wptr_q <= (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + 1'b1;
            if (do_pop)  rptr_q <= (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
            if (push_i && !push_ready_o) ovf_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_prim_arb_resp_router.sv
// Directed bench: scoreboard of grant indices, checked against routed valids.
module tb_prim_arb_resp_router;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Instance A: N=4, Depth=4
    logic        a_push, a_push_ready, a_rsp_valid, a_rsp_last, a_rsp_ready, a_last_o, a_ovf;
    logic [1:0]  a_push_idx;
    logic [31:0] a_data, a_data_o;
    logic [3:0]  a_valid_o, a_ready_i;
    logic [2:0]  a_cnt;

    // Instance B: N=4, Depth=3 (non-power-of-two wrap)
    logic        b_push, b_push_ready, b_rsp_valid, b_rsp_last, b_rsp_ready, b_last_o, b_ovf;
    logic [1:0]  b_push_idx;
    logic [31:0] b_data, b_data_o;
    logic [3:0]  b_valid_o, b_ready_i;
    logic [1:0]  b_cnt;

    prim_arb_resp_router #(.N(4), .DW(32), .Depth(4)) dut_a (
        .clk_i(clk), .rst_i(rst), .push_i(a_push), .push_idx_i(a_push_idx),
        .push_ready_o(a_push_ready), .rsp_valid_i(a_rsp_valid), .rsp_last_i(a_rsp_last),
        .rsp_data_i(a_data), .rsp_ready_o(a_rsp_ready), .rsp_valid_o(a_valid_o),
        .rsp_last_o(a_last_o), .rsp_data_o(a_data_o), .rsp_ready_i(a_ready_i),
        .cnt_o(a_cnt), .overflow_o(a_ovf));

    prim_arb_resp_router #(.N(4), .DW(32), .Depth(3)) dut_b (
        .clk_i(clk), .rst_i(rst), .push_i(b_push), .push_idx_i(b_push_idx),
        .push_ready_o(b_push_ready), .rsp_valid_i(b_rsp_valid), .rsp_last_i(b_rsp_last),
        .rsp_data_i(b_data), .rsp_ready_o(b_rsp_ready), .rsp_valid_o(b_valid_o),
        .rsp_last_o(b_last_o), .rsp_data_o(b_data_o), .rsp_ready_i(b_ready_i),
        .cnt_o(b_cnt), .overflow_o(b_ovf));

    int checks = 0;
    int errors = 0;
    int qa[$];
    int qb[$];
    bit done = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Routed valid must never light more than one port.
    always @(negedge clk) begin
        if (!done) begin
            checks++;
            assert ($onehot0(a_valid_o) && $onehot0(b_valid_o)) else begin
                errors++;
                $error("FAIL onehot0 observed=%0h/%0h expected=onehot0", a_valid_o, b_valid_o);
            end
        end
    end

    initial begin
        int e;
        logic [31:0] d;
        logic [3:0] rdy_seq [4];
        rst = 1'b1;
        a_push = 0; a_push_idx = 0; a_rsp_valid = 0; a_rsp_last = 0; a_data = 0; a_ready_i = 0;
        b_push = 0; b_push_idx = 0; b_rsp_valid = 0; b_rsp_last = 0; b_data = 0; b_ready_i = 0;
        step(); step();
        rst = 1'b0;
        #1;
        chk("rst_cnt", 32'(a_cnt), 0);
        chk("rst_push_ready", 32'(a_push_ready), 1);
        chk("rst_valid_o", 32'(a_valid_o), 0);
        chk("rst_rsp_ready", 32'(a_rsp_ready), 0);
        chk("rst_ovf", 32'(a_ovf), 0);

        // In-order routing of single-beat responses
        foreach (rdy_seq[i]) rdy_seq[i] = 4'b0;
        a_push = 1;
        a_push_idx = 2; qa.push_back(2); step();
        a_push_idx = 0; qa.push_back(0); step();
        a_push_idx = 3; qa.push_back(3); step();
        a_push = 0; #1;
        chk("order_cnt_full", 32'(a_cnt), 3);
        for (int i = 0; i < 3; i++) begin
            d = $urandom;
            a_rsp_valid = 1; a_rsp_last = 1; a_data = d; a_ready_i = 4'hf; #1;
            e = qa.pop_front();
            chk("order_valid", 32'(a_valid_o), 32'(1 << e));
            chk("order_ready", 32'(a_rsp_ready), 1);
            chk("order_data", a_data_o, d);
            step();
            chk("order_cnt", 32'(a_cnt), 32'(2 - i));
        end
        a_rsp_valid = 0; a_rsp_last = 0;

        // Multi-beat response with back-pressure; other ports' ready ignored
        a_push = 1; a_push_idx = 1; qa.push_back(1); step();
        a_push = 0;
        rdy_seq[0] = 4'b0010; rdy_seq[1] = 4'b1101; rdy_seq[2] = 4'b0010; rdy_seq[3] = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            a_rsp_valid = 1; a_rsp_last = (i == 3); a_ready_i = rdy_seq[i]; a_data = 32'(i); #1;
            chk("beat_valid", 32'(a_valid_o), 32'(1 << qa[0]));
            chk("beat_ready", 32'(a_rsp_ready), 32'(rdy_seq[i][1]));
            chk("beat_last", 32'(a_last_o), 32'(i == 3));
            if (i == 3) void'(qa.pop_front());
            step();
            chk("beat_cnt", 32'(a_cnt), (i == 3) ? 0 : 1);
        end

        // Empty stalls response; push routes only from the next cycle
        a_rsp_valid = 1; a_rsp_last = 1; a_ready_i = 4'hf; a_push = 1; a_push_idx = 3; #1;
        chk("empty_ready", 32'(a_rsp_ready), 0);
        chk("empty_valid", 32'(a_valid_o), 0);
        qa.push_back(3); step();
        a_push = 0; #1;
        chk("after_push_valid", 32'(a_valid_o), 32'(1 << qa.pop_front()));
        chk("after_push_ready", 32'(a_rsp_ready), 1);
        step();
        a_rsp_valid = 0; #1;
        chk("after_push_cnt", 32'(a_cnt), 0);

        // Fill, then overflow
        a_push = 1;
        for (int i = 0; i < 4; i++) begin
            a_push_idx = 2'(i); qa.push_back(i); step();
        end
        a_push = 0; #1;
        chk("full_cnt", 32'(a_cnt), 4);
        chk("full_push_ready", 32'(a_push_ready), 0);
        chk("full_ovf_pre", 32'(a_ovf), 0);
        a_push = 1; a_push_idx = 1; step();
        a_push = 0; #1;
        chk("ovf_cnt", 32'(a_cnt), 4);
        chk("ovf_set", 32'(a_ovf), 1);
        step();
        chk("ovf_sticky", 32'(a_ovf), 1);

        // Full: push and pop together -> push refused
        a_push = 1; a_push_idx = 2; a_rsp_valid = 1; a_rsp_last = 1; a_ready_i = 4'hf; #1;
        chk("fullpp_valid", 32'(a_valid_o), 32'(1 << qa.pop_front()));
        step();
        a_rsp_valid = 0; #1;
        chk("fullpp_cnt", 32'(a_cnt), 3);
        chk("fullpp_push_ready", 32'(a_push_ready), 1);
        qa.push_back(2); step();
        a_push = 0; #1;
        chk("refill_cnt", 32'(a_cnt), 4);
        while (qa.size() > 0) begin
            a_rsp_valid = 1; a_rsp_last = 1; #1;
            chk("drain_valid", 32'(a_valid_o), 32'(1 << qa.pop_front()));
            step();
        end
        a_rsp_valid = 0; #1;
        chk("drain_cnt", 32'(a_cnt), 0);

        // Reset mid multi-beat response, with a simultaneous push
        a_push = 1; a_push_idx = 1; step();
        a_push = 0; a_rsp_valid = 1; a_rsp_last = 0; step();
        rst = 1; a_push = 1; step();
        rst = 0; a_push = 0; #1;
        chk("midrst_cnt", 32'(a_cnt), 0);
        chk("midrst_ovf", 32'(a_ovf), 0);
        chk("midrst_valid", 32'(a_valid_o), 0);
        chk("midrst_ready", 32'(a_rsp_ready), 0);
        a_rsp_valid = 0;

        // Depth=3: push/pop pairs across pointer wrap
        b_ready_i = 4'hf; b_rsp_last = 1;
        b_push = 1;
        b_push_idx = 0; qb.push_back(0); step();
        b_push_idx = 1; qb.push_back(1); step();
        for (int i = 2; i < 7; i++) begin
            b_push_idx = 2'(i % 4); b_rsp_valid = 1; #1;
            chk("wrap_valid", 32'(b_valid_o), 32'(1 << qb.pop_front()));
            qb.push_back(i % 4); step();
            chk("wrap_cnt", 32'(b_cnt), 2);
        end
        b_push = 0;
        while (qb.size() > 0) begin
            #1;
            chk("wrap_drain", 32'(b_valid_o), 32'(1 << qb.pop_front()));
            step();
        end
        b_rsp_valid = 0; #1;
        chk("wrap_end_cnt", 32'(b_cnt), 0);
        chk("wrap_ovf", 32'(b_ovf), 0);

        done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
